pipe_stage_reg: RTL

- Parametrised pipeline stage register for the multi-cycle/pipelined CPU datapath; successor to the plain 32-bit CE register.
- Adds a valid/ready handshake, synchronous flush, and a configurable reset value.
- Adds an optional two-entry skid buffer, so ready can be registered without bubbles.
- Instantiated between IF/ID/EX/MEM/WB stages and on any datapath link that needs stall/flush.

---
 rtl/cpu_pipe_pkg.sv | 25 ++
 rtl/pipe_data_reg.sv | 34 +++
 rtl/pipe_stage_reg.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared definitions for the CPU pipeline stage registers.
//   - DefaultWidth : default payload width of a pipeline link
//   - ST_*         : encoding of the stage occupancy states
//   - stage_state_e: typed view of the same encoding for FSM code
//   - occupancy_of : entry count from the two valid bits
package cpu_pipe_pkg;

  localparam int unsigned DefaultWidth = 32;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef enum logic [1:0] {
    StEmpty = ST_EMPTY,
    StOne   = ST_ONE,
    StTwo   = ST_TWO
  } stage_state_e;

  // Number of entries held by a stage, 0..2.
  function automatic logic [1:0] occupancy_of(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// pipe_data_reg: WIDTH-bit data register with load enable.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset, loads RESET_VAL
//   load_i : capture d_i on the next rising edge
//   d_i    : next data value
//   q_o    : registered data
// Only the payload lives here; the valid bits are owned by the handshake
// logic in pipe_stage_reg.
module pipe_data_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned       WIDTH     = DefaultWidth,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RESET_VAL;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with valid/ready handshake,
// synchronous flush and an optional two-entry skid buffer.
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset, drops all entries
//   flush_i      : synchronous flush, discards all held entries
//   in_valid_i   : upstream offers in_data_i
//   in_ready_o   : stage can accept; transfer when in_valid_i & in_ready_o
//   in_data_i    : upstream payload
//   out_valid_o  : out_data_o holds a valid entry
//   out_ready_i  : downstream accepts; transfer when out_valid_o & out_ready_i
//   out_data_o   : payload at the head of the stage
//   occupancy_o  : number of held entries (0..2, at most 1 when SKID=0)
//
// SKID=1: two entries (main = head, skid = second) and in_ready_o comes
// straight from a flop, so upstream ready paths are cut without bubbles.
// SKID=0: one entry, in_ready_o is combinational from out_ready_i.
// In both modes data and valid reach the output one cycle after acceptance.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = DefaultWidth,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SKID      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       occupancy_o
);

  logic             main_valid;
  logic             skid_valid;
  logic             main_load;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_data;
  logic             acc;
  logic             pop;

  assign acc = in_valid_i & in_ready_o;
  assign pop = out_valid_o & out_ready_i;

  // Head entry; out_data_o always shows it, valid or not.
  pipe_data_reg #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .load_i(main_load),
    .d_i   (main_d),
    .q_o   (main_data)
  );

  if (SKID) begin : g_skid
    stage_state_e     state_q;
    logic             in_ready_q;
    logic             skid_load;
    logic [WIDTH-1:0] skid_data;

    // in_ready_q tracks ~skid_valid but is its own flop so that the ready
    // output has no logic in front of it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q    <= StEmpty;
        in_ready_q <= 1'b1;
      end else if (flush_i) begin
        state_q    <= StEmpty;
        in_ready_q <= 1'b1;
      end else begin
        unique case (state_q)
          StEmpty: begin
            if (acc) begin
              state_q <= StOne;
            end
          end
          StOne: begin
            if (acc && !pop) begin
              state_q    <= StTwo;
              in_ready_q <= 1'b0;
            end else if (!acc && pop) begin
              state_q <= StEmpty;
            end
          end
          StTwo: begin
            // No accept can happen here: in_ready_q is low.
            if (pop) begin
              state_q    <= StOne;
              in_ready_q <= 1'b1;
            end
          end
          default: begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
          end
        endcase
      end
    end

    // Data register load control. Flush gates every load so the held data
    // (and therefore out_data_o) keeps its last value.
    always_comb begin
      main_load = 1'b0;
      skid_load = 1'b0;
      main_d    = in_data_i;
      if (!flush_i) begin
        case (state_q)
          StEmpty: main_load = acc;
          StOne: begin
            main_load = acc & pop;
            skid_load = acc & ~pop;
          end
          StTwo: begin
            // Second entry moves up to the head as the head leaves.
            main_load = pop;
            main_d    = skid_data;
          end
          default: ;
        endcase
      end
    end

    pipe_data_reg #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_skid (
      .clk   (clk),
      .rst   (rst),
      .load_i(skid_load),
      .d_i   (in_data_i),
      .q_o   (skid_data)
    );

    assign main_valid = (state_q != StEmpty);
    assign skid_valid = (state_q == StTwo);
    assign in_ready_o = in_ready_q;

  end else begin : g_single
    logic main_valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_valid_q <= 1'b0;
      end else if (flush_i) begin
        main_valid_q <= 1'b0;
      end else if (acc) begin
        main_valid_q <= 1'b1;
      end else if (pop) begin
        main_valid_q <= 1'b0;
      end
    end

    // Same as the old CE register with CE = accept.
    assign main_load  = acc & ~flush_i;
    assign main_d     = in_data_i;
    assign main_valid = main_valid_q;
    assign skid_valid = 1'b0;
    // While rst is held the stage only mirrors out_ready_i; once released
    // an empty stage is always ready.
    assign in_ready_o = (~main_valid_q & ~rst) | out_ready_i;
  end

  assign out_valid_o = main_valid;
  assign out_data_o  = main_data;
  assign occupancy_o = occupancy_of(main_valid, skid_valid);

  // The second entry is only ever filled behind a valid head.
  a_skid_implies_main: assert property (
    @(posedge clk) disable iff (rst) skid_valid |-> main_valid
  );

  // A stalled output entry stays put until it is popped or flushed.
  a_out_stable: assert property (
    @(posedge clk) disable iff (rst)
      (out_valid_o && !out_ready_i && !flush_i) |=> (out_valid_o && $stable(out_data_o))
  );

endmodule
